// File: rtl/arb_pkg.sv
// Shared select encoding and reset priority
// for the two-input round-robin arbiter.
package arb_pkg;
   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;
   localparam logic RESET_LAST_GRANT = SEL_B;
endpackage

// File: rtl/mux.sv
// Parameterized 2:1 word multiplexer.
// c=0 passes a, c=1 passes b.
module mux #(
   parameter int WIDTH = 8
) (
   output logic [WIDTH-1:0] y,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c
);
   assign y = c ? b : a;
endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter feeding
// a one-entry registered output stage.
module rr_arb2
   import arb_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a_data,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [WIDTH-1:0] b_data,
   input  logic             b_valid,
   output logic             b_ready,
   output logic             sel,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             last_grant
);
   logic [WIDTH-1:0] mux_y;
   logic             load;
   logic             xfer;

   mux #(.WIDTH(WIDTH)) u_mux (
      .y (mux_y),
      .a (a_data),
      .b (b_data),
      .c (sel)
   );

   // Idle cycles keep the previous grant so sel does not toggle.
   always_comb begin
      sel = last_grant;
      if (a_valid && b_valid)
         sel = ~last_grant;
      else if (a_valid)
         sel = SEL_A;
      else if (b_valid)
         sel = SEL_B;
   end

   assign load = !out_valid || out_ready;

   assign a_ready = !rst && load && a_valid
                    && (sel == SEL_A);
   assign b_ready = !rst && load && b_valid
                    && (sel == SEL_B);
   assign xfer = a_ready || b_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data   <= '0;
         out_valid  <= 1'b0;
         last_grant <= RESET_LAST_GRANT;
      end else if (xfer) begin
         out_data   <= mux_y;
         out_valid  <= 1'b1;
         last_grant <= sel;
      end else if (out_valid && out_ready) begin
         out_valid  <= 1'b0;
      end
   end
endmodule

// File: tb/tb_rr_arb2.sv
// Scoreboard bench for rr_arb2: directed
// scenarios followed by random traffic.
module tb_rr_arb2;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] a_data = '0;
   logic       a_valid = 1'b0;
   logic       a_ready;
   logic [7:0] b_data = '0;
   logic       b_valid = 1'b0;
   logic       b_ready;
   logic       sel;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       last_grant;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference: occupancy of the output slot,
   // who was served last, and words in flight.
   bit         m_full = 0;
   bit         m_last = 1;
   logic [7:0] exp_q[$];

   rr_arb2 #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .a_data     (a_data),
      .a_valid    (a_valid),
      .a_ready    (a_ready),
      .b_data     (b_data),
      .b_valid    (b_valid),
      .b_ready    (b_ready),
      .sel        (sel),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .last_grant (last_grant)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [7:0] act,
                      input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h @%0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_full = 0;
      m_last = 1;
      exp_q.delete();
   endtask

   // One clock cycle of stimulus with the
   // model deciding who should be accepted.
   task automatic cyc(input logic av,
                      input logic [7:0] ad,
                      input logic bv,
                      input logic [7:0] bd,
                      input logic ordy);
      int win;
      bit room;
      @(negedge clk);
      a_valid = av;
      a_data = ad;
      b_valid = bv;
      b_data = bd;
      out_ready = ordy;
      #1;
      win = -1;
      if (av && bv) win = m_last ? 0 : 1;
      else if (av) win = 0;
      else if (bv) win = 1;
      room = !m_full || ordy;
      chk("out_valid", {7'd0, out_valid}, {7'd0, m_full});
      chk("last_grant", {7'd0, last_grant}, {7'd0, m_last});
      chk("sel", {7'd0, sel},
          (win < 0) ? {7'd0, m_last} : 8'(win));
      chk("a_ready", {7'd0, a_ready},
          {7'd0, room && win == 0});
      chk("b_ready", {7'd0, b_ready},
          {7'd0, room && win == 1});
      if (room && win >= 0) begin
         exp_q.push_back(win == 0 ? ad : bd);
         m_full = 1;
         m_last = win[0];
      end else if (ordy) begin
         m_full = 0;
      end
   endtask

   // Monitor: every output handshake retires
   // the oldest expected word.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL out_data: got %0h expected none",
                        out_data);
            end else begin
               e = exp_q.pop_front();
               chk("out_data", out_data, e);
            end
         end
      end
   end

   initial begin
      // Reset with valids raised: readies must stay low.
      a_valid = 1'b1;
      b_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst out_valid", {7'd0, out_valid}, 8'd0);
      chk("rst out_data", out_data, 8'd0);
      chk("rst a_ready", {7'd0, a_ready}, 8'd0);
      chk("rst b_ready", {7'd0, b_ready}, 8'd0);
      chk("rst last_grant", {7'd0, last_grant}, 8'd1);
      @(negedge clk);
      a_valid = 1'b0;
      b_valid = 1'b0;
      rst = 1'b0;
      model_reset();
      cyc(0, 8'h00, 0, 8'h00, 0);
      cyc(0, 8'h00, 0, 8'h00, 1);

      // Single sources then drain.
      cyc(1, 8'h19, 0, 8'h00, 1);
      cyc(0, 8'h00, 0, 8'h00, 1);
      cyc(0, 8'h00, 1, 8'h2A, 1);
      cyc(0, 8'h00, 0, 8'h00, 1);
      cyc(0, 8'h00, 0, 8'h00, 1);

      // Contention: A,B,A,B.
      repeat (4) cyc(1, 8'h19, 1, 8'h2A, 1);

      // Backpressure, then release with no bubble.
      repeat (3) cyc(1, 8'h19, 1, 8'h2A, 0);
      repeat (2) cyc(1, 8'h19, 1, 8'h2A, 1);

      // Valid withdrawal under stall.
      cyc(0, 8'h00, 1, 8'h33, 0);
      cyc(0, 8'h00, 1, 8'h44, 0);
      cyc(0, 8'h00, 0, 8'h00, 0);
      cyc(0, 8'h00, 0, 8'h00, 0);

      // Async reset while the output slot is full.
      cyc(1, 8'h55, 0, 8'h00, 0);
      cyc(0, 8'h00, 0, 8'h00, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("async out_valid", {7'd0, out_valid}, 8'd0);
      chk("async last_grant", {7'd0, last_grant}, 8'd1);
      chk("async out_data", out_data, 8'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cyc(1, 8'h61, 1, 8'h62, 1);
      cyc(1, 8'h63, 1, 8'h64, 1);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         cyc($urandom_range(0, 1) == 1,
             8'($urandom),
             $urandom_range(0, 1) == 1,
             8'($urandom),
             $urandom_range(0, 3) != 0);
      end

      repeat (3) cyc(0, 8'h00, 0, 8'h00, 1);
      chk("queue empty", 8'(exp_q.size()), 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
